// File: rtl/tb_obi_mem_mp_pkg.sv
// Shared types and helpers for the multi-port OBI bench memory.
//   resp_entry_t    : one response-pipeline stage {valid, port_id, rdata}
//   port_idx_width  : bits needed to index NUM_PORTS ports (minimum 1)
//   DEFAULT_EXIT_ADDR : default MMIO address of the exit register
package tb_obi_mem_pkg;

   localparam logic [31:0] DEFAULT_EXIT_ADDR = 32'h2000_0004;

   // Wide enough for the largest supported port count (8).
   localparam int unsigned PORT_ID_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [PORT_ID_W-1:0] port_id;
      logic [31:0]          rdata;
   } resp_entry_t;

   function automatic int unsigned port_idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tb_obi_mem_mp_if.sv
// Per-port OBI-style request/response bundle, NUM_PORTS lanes wide.
//   req_i, addr_i, we_i, be_i, wdata_i : request channel (master -> memory)
//   stall_i                            : bench-driven grant inhibit
//   gnt_o                              : grant, combinational in the request cycle
//   rvalid_o, rdata_o                  : response channel (memory -> master)
interface tb_obi_mem_mp_if #(
   parameter int unsigned NUM_PORTS = 2
);
   logic [NUM_PORTS-1:0]    req_i;
   logic [NUM_PORTS-1:0]    gnt_o;
   logic [NUM_PORTS*32-1:0] addr_i;
   logic [NUM_PORTS-1:0]    we_i;
   logic [NUM_PORTS*4-1:0]  be_i;
   logic [NUM_PORTS*32-1:0] wdata_i;
   logic [NUM_PORTS-1:0]    stall_i;
   logic [NUM_PORTS-1:0]    rvalid_o;
   logic [NUM_PORTS*32-1:0] rdata_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i, stall_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i, stall_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/tb_obi_mem_mp_arbiter.sv
// Round-robin arbiter: grants at most one eligible port per cycle, searching
// upward from the pointer; the pointer moves past the winner on a grant.
//   clk_i, rst_i : clock, synchronous active-high reset
//   elig         : per-port eligibility
//   grant        : one-hot grant
//   any_grant    : a grant was issued this cycle
//   grant_idx    : index of the granted port
module tb_rr_arbiter
   import tb_obi_mem_pkg::*;
#(
   parameter int unsigned  NUM_PORTS = 2,
   localparam int unsigned PW        = port_idx_width(NUM_PORTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_PORTS-1:0] elig,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 any_grant,
   output logic [PW-1:0]        grant_idx
);

   logic [PW-1:0] ptr;
   logic [PW-1:0] idx;

   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = PW'((32'(ptr) + i) % NUM_PORTS);
         if (!any_grant && elig[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (any_grant) begin
         ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

endmodule

// File: rtl/tb_obi_mem_mp.sv
// Multi-port bench memory: NUM_PORTS OBI-style channels share one word RAM
// through a round-robin arbiter, with fixed response latency, per-port
// outstanding limits, bench grant stalling and an MMIO exit register.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : request/response lanes (slave side)
//   exit_valid_o  : sticky, set by any write to EXIT_ADDR
//   exit_value_o  : last value written to EXIT_ADDR
module tb_obi_mem_mp
   import tb_obi_mem_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned ADDR_WIDTH      = 20,
   parameter int unsigned RESP_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] EXIT_ADDR       = DEFAULT_EXIT_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   tb_obi_mem_mp_if.slave bus,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
   localparam int unsigned PW    = port_idx_width(NUM_PORTS);
   localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]             mem [DEPTH];
   resp_entry_t             pipe [RESP_LATENCY];
   resp_entry_t             tail;
   logic [CW-1:0]           outstanding [NUM_PORTS];

   logic [NUM_PORTS-1:0]    elig;
   logic [NUM_PORTS-1:0]    grant;
   logic [NUM_PORTS-1:0]    rvalid;
   logic [NUM_PORTS*32-1:0] rdata;
   logic                    any_grant;
   logic [PW-1:0]           grant_idx;

   logic [31:0]             sel_addr;
   logic [31:0]             sel_wdata;
   logic [3:0]              sel_be;
   logic                    sel_we;
   logic                    sel_exit;
   logic [ADDR_WIDTH-3:0]   word_idx;
   logic [31:0]             rd_word;

   // A response retiring this cycle frees its slot, so a port at the limit
   // can be granted again in the same cycle its oldest response returns.
   always_comb begin
      elig = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         elig[p] = bus.req_i[p] & ~bus.stall_i[p] & ~rst_i &
                   ((outstanding[p] < CW'(MAX_OUTSTANDING)) | rvalid[p]);
      end
   end

   tb_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .elig      (elig),
      .grant     (grant),
      .any_grant (any_grant),
      .grant_idx (grant_idx)
   );

   assign bus.gnt_o = grant;

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_we    = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_addr  = bus.addr_i[p*32 +: 32];
            sel_wdata = bus.wdata_i[p*32 +: 32];
            sel_be    = bus.be_i[p*4 +: 4];
            sel_we    = bus.we_i[p];
         end
      end
   end

   assign sel_exit = (sel_addr == EXIT_ADDR);
   assign word_idx = sel_addr[ADDR_WIDTH-1:2];
   assign rd_word  = (sel_we || sel_exit) ? '0 : mem[word_idx];

   // RAM contents survive reset; grants are already suppressed during reset.
   always_ff @(posedge clk_i) begin
      if (any_grant && sel_we && !sel_exit) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sel_be[b]) mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < RESP_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{valid:   any_grant,
                      port_id: PORT_ID_W'(grant_idx),
                      rdata:   any_grant ? rd_word : '0};
         for (int unsigned i = 1; i < RESP_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tail = pipe[RESP_LATENCY-1];

   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (tail.valid && tail.port_id == PORT_ID_W'(p)) begin
            rvalid[p]          = 1'b1;
            rdata[p*32 +: 32]  = tail.rdata;
         end
      end
   end

   assign bus.rvalid_o = rvalid;
   assign bus.rdata_o  = rdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) outstanding[p] <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            case ({grant[p], rvalid[p]})
               2'b10:   outstanding[p] <= outstanding[p] + CW'(1);
               2'b01:   outstanding[p] <= outstanding[p] - CW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exit_valid_o <= 1'b0;
         exit_value_o <= '0;
      end else if (any_grant && sel_we && sel_exit) begin
         exit_valid_o <= 1'b1;
         exit_value_o <= sel_wdata;
      end
   end

endmodule
